somador_5bits: RTL and testbench
================================

// Module: somador_5bits
// PURPOSE
//   Parameterised ripple-carry adder; default 5 bits, sized for PC+4 in the
//   instruction-fetch path (a=PC, b=5'b00100, cin=0, sum=next PC).
//   sum/cout are purely combinational, so the PC register can consume them in the same cycle.
//   An optional registered copy of the result plus status flags serves pipelined users.
// PARAMETERS
//   WIDTH    5   operand/sum width in bits (legal range 1..32)
//   REG_OUT  1   1: build the registered output stage; 0: tie registered outputs to 0
// PORTS
//   clk       in   1      single clock, rising edge
//   reset     in   1      asynchronous, active-high; clears registered outputs only
//   a         in   WIDTH  operand A (unsigned or two's complement)
//   b         in   WIDTH  operand B
//   cin       in   1      carry in
//   cout      out  1      carry out of MSB, combinational
//   sum       out  WIDTH  (a+b+cin) mod 2^WIDTH, combinational
//   ovf       out  1      signed overflow = carry into MSB XOR carry out of MSB
//   zero      out  1      1 when sum == 0
//   sum_q     out  WIDTH  sum registered on rising clk edge
//   cout_q    out  1      cout registered
//   ovf_q     out  1      ovf registered
// BEHAVIOUR
//   - {cout,sum} = a + b + cin, exact WIDTH+1-bit result; there is no saturation.
//   - Wrap-around: 5'd31+5'd1+0 gives sum=0, cout=1, zero=1.
//   - Combinational outputs settle within the same cycle. They have no reset
//     dependence and stay valid while reset is asserted.
//   - Registered outputs have 1-cycle latency: on posedge clk, capture
//     sum_q<=sum, cout_q<=cout and ovf_q<=ovf.
//   - On reset assertion, sum_q, cout_q and ovf_q go to 0 immediately,
//     independent of clk. They hold 0 while reset is high.
//   - After reset deasserts, the first rising edge captures the current sum.
//   - If reset deasserts on the same edge as a capture, reset wins for that edge.
//   - There is no handshake and no enable: the registers capture every cycle.
//   - No X-propagation guard: X on any input gives X on all outputs.
//   - Ports are connected by name, because clk/reset precede the operands.
// STRUCTURE
//   - Sub-module full_adder (a,b,cin -> s,cout), instantiated WIDTH times in
//     a generate loop, forming a carry chain c[0]=cin to c[WIDTH]=cout.
//   - ovf = c[WIDTH] ^ c[WIDTH-1]; zero = ~|sum.
//   - Output register in one always block sensitive to (posedge clk, posedge reset).
//   - Shared package: localparam PC_STEP = 5'd4 and PC_WIDTH = 5, reused by
//     the fetch stage. The adder itself needs no typedefs.
// TESTING
//   1. a=0, b=4, cin=0 -> sum=4, cout=0, zero=0. Next edge: sum_q=4.
//   2. a=28, b=4, cin=0 -> sum=0, cout=1, zero=1, ovf=0 (PC wrap).
//   3. a=5'b01111, b=1, cin=0 -> sum=5'b10000, ovf=1, cout=0.
//      a=5'b10000, b=5'b11111, cin=0 -> sum=5'b01111, ovf=1, cout=1.
//   4. Exhaustive sweep of a, b in 0..31 and cin in {0,1} -> {cout,sum} == a+b+cin
//      for every vector; ovf and zero match the reference formulas.
//   5. Load sum_q=9, then assert reset between clock edges -> sum_q, cout_q and
//      ovf_q are 0 before the next edge, while comb sum still tracks inputs.
//      Deassert reset -> first edge reloads sum_q.
//   6. PC loop: feed sum back into a through a register for 10 cycles ->
//      sequence 0,4,8,...,28,0,4. cout pulses 1 on the 28->0 step.

Source files
------------

// File: rtl/somador_5bits_pkg.sv
// Shared constants for the instruction-fetch PC increment path.
package somador_5bits_pkg;

    localparam int unsigned PC_WIDTH = 5;
    localparam logic [4:0]  PC_STEP  = 5'd4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple chain in somador_5bits is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_5bits.sv
// Ripple-carry adder with combinational sum/flags for same-cycle PC update,
// plus an optional registered copy of the result for pipelined consumers.
module somador_5bits
    import somador_5bits_pkg::*;
#(
    parameter int unsigned WIDTH   = PC_WIDTH,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];
    assign zero = ~|sum;

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sum_q  <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end else begin : g_noreg
        assign sum_q  = '0;
        assign cout_q = 1'b0;
        assign ovf_q  = 1'b0;
    end

endmodule

// File: tb/tb_somador_5bits.sv
// Directed and exhaustive checks of somador_5bits: comb sum/flags, registered
// stage, asynchronous reset and a PC+4 feedback loop.
module tb_somador_5bits;
    import somador_5bits_pkg::*;

    localparam int unsigned W = 5;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         cout;
    logic [W-1:0] sum;
    logic         ovf;
    logic         zero;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    int tests_run;
    int tests_failed;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs [10];

    somador_5bits #(.WIDTH(W), .REG_OUT(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .cout   (cout),
        .sum    (sum),
        .ovf    (ovf),
        .zero   (zero),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Packs comb outputs as {cout, ovf, zero, sum} for one-line comparison.
    function automatic logic [31:0] pack_comb(input logic co, input logic ov, input logic z,
                                              input logic [W-1:0] s);
        return 32'({co, ov, z, s});
    endfunction

    initial begin
        logic [5:0]   full;
        logic [W-1:0] es;
        logic         eov;
        logic [W-1:0] exp_pc;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{a: 5'd0,  b: 5'd4,  cin: 1'b0, sum: 5'd4,  cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 5'd28, b: 5'd4,  cin: 1'b0, sum: 5'd0,  cout: 1'b1, ovf: 1'b0, zero: 1'b1};
        vecs[2] = '{a: 5'd15, b: 5'd1,  cin: 1'b0, sum: 5'd16, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
        vecs[3] = '{a: 5'd16, b: 5'd31, cin: 1'b0, sum: 5'd15, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 5'd31, b: 5'd1,  cin: 1'b0, sum: 5'd0,  cout: 1'b1, ovf: 1'b0, zero: 1'b1};
        vecs[5] = '{a: 5'd31, b: 5'd31, cin: 1'b1, sum: 5'd31, cout: 1'b1, ovf: 1'b0, zero: 1'b0};
        vecs[6] = '{a: 5'd0,  b: 5'd0,  cin: 1'b0, sum: 5'd0,  cout: 1'b0, ovf: 1'b0, zero: 1'b1};
        vecs[7] = '{a: 5'd0,  b: 5'd0,  cin: 1'b1, sum: 5'd1,  cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        vecs[8] = '{a: 5'd15, b: 5'd15, cin: 1'b1, sum: 5'd31, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
        vecs[9] = '{a: 5'd16, b: 5'd16, cin: 1'b0, sum: 5'd0,  cout: 1'b1, ovf: 1'b1, zero: 1'b1};

        reset = 1'b1;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #2;
        check("reset_sum_q",  32'(sum_q),  32'd0);
        check("reset_cout_q", 32'(cout_q), 32'd0);
        check("reset_ovf_q",  32'(ovf_q),  32'd0);

        // Directed table; comb outputs must be valid even while reset is held.
        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            #2;
            check($sformatf("vec%0d", i), pack_comb(cout, ovf, zero, sum),
                  pack_comb(vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].sum));
        end

        // Exhaustive sweep against an arithmetic model with sign-based overflow.
        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a = W'(ia); b = W'(ib); cin = 1'(ic);
                    full = 6'(ia) + 6'(ib) + 6'(ic);
                    es   = full[W-1:0];
                    eov  = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
                    #1;
                    check($sformatf("sweep a=%0d b=%0d cin=%0d", ia, ib, ic),
                          pack_comb(cout, ovf, zero, sum),
                          pack_comb(full[W], eov, (es == '0), es));
                end
            end
        end

        // Registered stage: load, then async reset between edges.
        @(negedge clk);
        reset = 1'b0;
        a = 5'd0; b = PC_STEP; cin = 1'b0;
        @(posedge clk); #1;
        check("reg_pc4_sum_q", 32'(sum_q), 32'd4);

        @(negedge clk);
        a = 5'd5; b = 5'd4;
        @(posedge clk); #1;
        check("reg_load9_sum_q", 32'(sum_q), 32'd9);

        @(negedge clk);
        a = 5'd16; b = 5'd31;
        @(posedge clk); #1;
        check("reg_flags", 32'({cout_q, ovf_q, sum_q}), 32'({1'b1, 1'b1, 5'd15}));

        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_rst_sum_q",  32'(sum_q),  32'd0);
        check("async_rst_cout_q", 32'(cout_q), 32'd0);
        check("async_rst_ovf_q",  32'(ovf_q),  32'd0);
        a = 5'd1; b = 5'd4;
        #1;
        check("comb_during_rst", 32'(sum), 32'd5);
        @(posedge clk); #1;
        check("held_in_rst", 32'({cout_q, ovf_q, sum_q}), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("still_0_after_deassert", 32'(sum_q), 32'd0);
        @(posedge clk); #1;
        check("reload_after_rst", 32'(sum_q), 32'd5);

        // PC loop: a follows the registered sum; expected sequence from a model.
        @(negedge clk);
        a = 5'd0; b = PC_STEP; cin = 1'b0;
        exp_pc = 5'd0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("pc_loop%0d_sum", k), 32'(sum), 32'(W'(exp_pc + 5'd4)));
            check($sformatf("pc_loop%0d_cout", k), 32'(cout), 32'(exp_pc == 5'd28));
            @(posedge clk); #1;
            exp_pc = W'(exp_pc + 5'd4);
            check($sformatf("pc_loop%0d_sum_q", k), 32'(sum_q), 32'(exp_pc));
            a = sum_q;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
